// File: rtl/rojobot_move_ctrl.sv
// -----------------------------------------------------------------------------
// rojobot_move_ctrl
//
// Command sequencer for the RojoBot wheel-counter model. It accepts one move
// command at a time over a valid/ready handshake. It drives the four wheel
// pushbutton inputs and watches the 8-bit wheel position counters until every
// driven wheel has travelled the commanded number of ticks. It then pulses
// done and reports a status code.
//
// Parameters
//   SIMULATE     1 selects a short watchdog limit for simulation.
//   TIMEOUT_CYC  cycles without wheel movement before a move times out.
//
// Build option
//   MOVE_CTRL_WDOG_EN  when defined, adds the 26-bit no-movement watchdog.
//                      When undefined, a move ends only on completion or
//                      abort, and status 10 is never produced.
//
// Ports
//   clk, reset_n           100 MHz clock; asynchronous active-low reset
//   cmd_valid / cmd_ready  command handshake; ready is high only in IDLE
//   cmd_op [2:0]           move opcode
//   cmd_cnt [7:0]          ticks to travel per driven wheel
//   abort                  ends the current move (ignored outside RUN)
//   left_pos, right_pos    wheel position counters from the RojoBot
//   left_fwd, left_rev,
//   right_fwd, right_rev   registered wheel drive outputs
//   busy                   high while a move is running
//   done                   one-cycle completion pulse
//   status [1:0]           00 ok, 01 aborted, 10 timeout, 11 illegal op
// -----------------------------------------------------------------------------
module rojobot_move_ctrl #(
   parameter int          SIMULATE    = 0,
   parameter logic [25:0] TIMEOUT_CYC = (SIMULATE != 0) ? 26'd12 : 26'd40_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [7:0] cmd_cnt,
   input  logic       abort,
   input  logic [7:0] left_pos,
   input  logic [7:0] right_pos,
   output logic       left_fwd,
   output logic       left_rev,
   output logic       right_fwd,
   output logic       right_rev,
   output logic       busy,
   output logic       done,
   output logic [1:0] status
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ABORT   = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_ILLEGAL = 2'b11;

   // Wheel directions for an opcode, packed {left_fwd, left_rev, right_fwd, right_rev}.
   function automatic logic [3:0] op_dirs(input logic [2:0] op);
      case (op)
         3'b001:  op_dirs = 4'b1010;  // FWD
         3'b010:  op_dirs = 4'b0101;  // REV
         3'b011:  op_dirs = 4'b0110;  // SPIN_L
         3'b100:  op_dirs = 4'b1001;  // SPIN_R
         3'b101:  op_dirs = 4'b0010;  // PIVOT_L
         3'b110:  op_dirs = 4'b1000;  // PIVOT_R
         default: op_dirs = 4'b0000;  // STOP, illegal
      endcase
   endfunction

   // Modulo-256 distance travelled; correct across the 255->0 wrap because
   // a move never exceeds 255 ticks.
   function automatic logic [7:0] wheel_dist(input logic fwd, input logic [7:0] pos,
                                             input logic [7:0] start);
      wheel_dist = fwd ? (pos - start) : (start - pos);
   endfunction

   state_t     state, state_nx;
   logic [3:0] drv_q, drv_nx;
   logic [1:0] status_q, status_nx;
   logic [7:0] start_l, start_r, cnt_q;
   logic [2:0] op_q;
   logic [3:0] dirs_q;
   logic       left_drv, right_drv;
   logic [7:0] dist_l, dist_r;
   logic       fin_l, fin_r;
   logic       accept;
   logic       timeout;

   assign accept    = (state == IDLE) && cmd_valid;
   assign dirs_q    = op_dirs(op_q);
   assign left_drv  = dirs_q[3] | dirs_q[2];
   assign right_drv = dirs_q[1] | dirs_q[0];
   assign dist_l    = wheel_dist(dirs_q[3], left_pos, start_l);
   assign dist_r    = wheel_dist(dirs_q[1], right_pos, start_r);
   // Undriven wheels never hold up completion.
   assign fin_l     = !left_drv  || (dist_l >= cnt_q);
   assign fin_r     = !right_drv || (dist_r >= cnt_q);

`ifdef MOVE_CTRL_WDOG_EN
   logic [25:0] wdog_cnt;
   logic [7:0]  prev_l, prev_r;
   logic        pos_moved;

   assign pos_moved = (left_drv  && (left_pos  != prev_l)) ||
                      (right_drv && (right_pos != prev_r));
   // Fires on the TIMEOUT_CYC-th consecutive RUN cycle without movement.
   assign timeout   = (state == RUN) && !pos_moved && (wdog_cnt >= (TIMEOUT_CYC - 26'd1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wdog_cnt <= '0;
         prev_l   <= '0;
         prev_r   <= '0;
      end else begin
         prev_l <= left_pos;
         prev_r <= right_pos;
         // Held at zero outside RUN, so every move starts with a clear count.
         if ((state == RUN) && !pos_moved)
            wdog_cnt <= wdog_cnt + 26'd1;
         else
            wdog_cnt <= '0;
      end
   end
`else
   // No watchdog in this build: a move ends only on completion or abort.
   assign timeout = 1'b0 & (TIMEOUT_CYC != 26'd0);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         drv_q    <= '0;
         status_q <= ST_OK;
      end else begin
         state    <= state_nx;
         drv_q    <= drv_nx;
         status_q <= status_nx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_l <= '0;
         start_r <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
      end else if (accept) begin
         start_l <= left_pos;
         start_r <= right_pos;
         op_q    <= cmd_op;
         cnt_q   <= cmd_cnt;
      end
   end

   always_comb begin
      state_nx  = state;
      drv_nx    = drv_q;
      status_nx = status_q;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               drv_nx    = 4'b0000;
               status_nx = ST_OK;
               if (cmd_op == 3'b111) begin
                  state_nx  = DONE;
                  status_nx = ST_ILLEGAL;
               end else if ((cmd_op == 3'b000) || (cmd_cnt == 8'd0)) begin
                  state_nx = DONE;
               end else begin
                  state_nx = RUN;
                  drv_nx   = op_dirs(cmd_op);
               end
            end
         end
         RUN: begin
            // A finished wheel drops its drive while the other keeps going.
            drv_nx = drv_q & ~{fin_l, fin_l, fin_r, fin_r};
            // Completion outranks abort, abort outranks timeout.
            if (fin_l && fin_r) begin
               state_nx  = DONE;
               drv_nx    = 4'b0000;
               status_nx = ST_OK;
            end else if (abort) begin
               state_nx  = DONE;
               drv_nx    = 4'b0000;
               status_nx = ST_ABORT;
            end else if (timeout) begin
               state_nx  = DONE;
               drv_nx    = 4'b0000;
               status_nx = ST_TIMEOUT;
            end
         end
         DONE: begin
            state_nx = IDLE;
            drv_nx   = 4'b0000;
         end
         default: begin
            state_nx = IDLE;
            drv_nx   = 4'b0000;
         end
      endcase
   end

   assign {left_fwd, left_rev, right_fwd, right_rev} = drv_q;
   assign cmd_ready = (state == IDLE);
   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign status    = status_q;

endmodule

// File: tb/tb_rojobot_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rojobot_move_ctrl
//
// Bench for rojobot_move_ctrl. A small wheel model in the bench moves the
// position counters one tick at a time in whichever direction the DUT drives.
// A reference model tracks the remaining ticks per wheel, the cycle the move
// must end and the resulting status, and predicts busy, done, cmd_ready and
// the drive outputs cycle by cycle.
// -----------------------------------------------------------------------------
module tb_rojobot_move_ctrl;

   localparam int TMO = 12;
`ifdef MOVE_CTRL_WDOG_EN
   localparam bit WDOG = 1'b1;
`else
   localparam bit WDOG = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_cnt;
   logic       abort;
   logic [7:0] left_pos, right_pos;
   logic       left_fwd, left_rev, right_fwd, right_rev;
   logic       busy, done;
   logic [1:0] status;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Signed wheel direction per opcode: +1 forward, -1 reverse, 0 undriven.
   int LDIR [8] = '{0, 1, -1, -1, 1, 0, 1, 0};
   int RDIR [8] = '{0, 1, -1, 1, -1, 1, 0, 0};

   typedef struct {
      logic [2:0] op;
      logic [7:0] cnt;
      logic [7:0] sl;
      logic [7:0] sr;
      int         tick_pct;
      int         abort_tick;
      int         abort_cyc;
      logic [1:0] st;
      logic [7:0] el;
      logic [7:0] er;
   } vec_t;

   vec_t vecs [12];

   logic [2:0] r_op;
   logic [7:0] r_cnt;
   int         r_sel, r_tp, r_ac, acc;

   always #5 clk = ~clk;

   rojobot_move_ctrl #(.SIMULATE(1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_cnt   (cmd_cnt),
      .abort     (abort),
      .left_pos  (left_pos),
      .right_pos (right_pos),
      .left_fwd  (left_fwd),
      .left_rev  (left_rev),
      .right_fwd (right_fwd),
      .right_rev (right_rev),
      .busy      (busy),
      .done      (done),
      .status    (status)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_ready();
      for (int w = 0; w < 20 && cmd_ready !== 1'b1; w++) step();
      chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
   endtask

   // Issue one command, run the wheel model and check every cycle until the
   // cycle after done.
   task automatic do_cmd(input logic [2:0] op, input logic [7:0] cnt,
                         input logic [7:0] sl, input logic [7:0] sr,
                         input int tick_pct, input int abort_tick, input int abort_cyc,
                         input int abort_pct, input bit use_exp, input logic [1:0] exp_st,
                         input logic [7:0] exp_l, input logic [7:0] exp_r);
      int         a, fin, rem_l, rem_r, stall, moves, ld, rd, t;
      bit         immed, moved, abort_now, busy_e, ended;
      logic [1:0] m_st, want_st;
      logic [7:0] m_l, m_r;
      logic [3:0] drv_e;
      ld = LDIR[op];
      rd = RDIR[op];
      wait_ready();
      left_pos  = sl;
      right_pos = sr;
      cmd_op    = op;
      cmd_cnt   = cnt;
      cmd_valid = 1'b1;
      abort     = (int'($urandom_range(99)) < abort_pct);  // must be ignored in IDLE
      a         = cyc;
      immed     = (op == 3'd0) || (op == 3'd7) || (cnt == 8'd0);
      m_st      = (op == 3'd7) ? 2'd3 : 2'd0;
      rem_l     = (!immed && ld != 0) ? int'(cnt) : 0;
      rem_r     = (!immed && rd != 0) ? int'(cnt) : 0;
      fin       = immed ? a : -1;
      m_l       = (ld > 0) ? sl + cnt : (ld < 0) ? sl - cnt : sl;
      m_r       = (rd > 0) ? sr + cnt : (rd < 0) ? sr - cnt : sr;
      stall     = 0;
      moves     = 0;
      ended     = 1'b0;
      step();
      cmd_valid = 1'b0;
      abort     = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         t      = cyc;
         busy_e = (fin < 0) || (t <= fin);
         drv_e  = {busy_e && ld > 0 && rem_l > 0, busy_e && ld < 0 && rem_l > 0,
                   busy_e && rd > 0 && rem_r > 0, busy_e && rd < 0 && rem_r > 0};
         chk("busy", 32'(busy), 32'(busy_e));
         chk("done", 32'(done), 32'(fin >= 0 && t == fin + 1));
         chk("cmd_ready_low", 32'(cmd_ready), 32'd0);
         chk("drives", 32'({left_fwd, left_rev, right_fwd, right_rev}), 32'(drv_e));
         if (fin >= 0 && t == fin + 1) begin
            ended = 1'b1;
            break;
         end
         moved = 1'b0;
         if ((left_fwd || left_rev) && int'($urandom_range(99)) < tick_pct) begin
            left_pos = left_fwd ? left_pos + 8'd1 : left_pos - 8'd1;
            moved = 1'b1;
            if (rem_l > 0) rem_l--;
         end
         if ((right_fwd || right_rev) && int'($urandom_range(99)) < tick_pct) begin
            right_pos = right_fwd ? right_pos + 8'd1 : right_pos - 8'd1;
            moved = 1'b1;
            if (rem_r > 0) rem_r--;
         end
         if (moved) moves++;
         stall = moved ? 0 : stall + 1;
         abort_now = (abort_tick > 0 && moved && moves == abort_tick) ||
                     (abort_cyc > 0 && t == a + abort_cyc) ||
                     (int'($urandom_range(99)) < abort_pct);
         abort = abort_now;
         if (fin < 0) begin
            if (rem_l == 0 && rem_r == 0) begin
               fin = t; m_st = 2'd0;
            end else if (abort_now) begin
               fin = t; m_st = 2'd1;
            end else if (WDOG && stall >= TMO) begin
               fin = t; m_st = 2'd2;
            end
         end
         step();
         abort = 1'b0;
      end
      chk("cmd_ended", 32'(ended), 32'd1);
      want_st = use_exp ? exp_st : m_st;
      chk("status", 32'(status), 32'(want_st));
      if (use_exp) begin
         chk("left_pos_final", 32'(left_pos), 32'(exp_l));
         chk("right_pos_final", 32'(right_pos), 32'(exp_r));
      end else if (m_st == 2'd0) begin
         chk("left_pos_final", 32'(left_pos), 32'(m_l));
         chk("right_pos_final", 32'(right_pos), 32'(m_r));
      end
      step();
      chk("ready_after_done", 32'(cmd_ready), 32'd1);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("status_hold", 32'(status), 32'(want_st));
      chk("drives_idle", 32'({left_fwd, left_rev, right_fwd, right_rev}), 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout at cycle %0d: got no end, expected summary", cyc);
      $fatal(1, "bench time limit reached");
   end

   initial begin
      //            op     cnt     sl      sr      tick abt_t abt_c status  el      er
      vecs[0]  = '{3'd1, 8'd3,   8'd0,   8'd0,   100, 0, 0,  2'd0, 8'd3,   8'd3};
      vecs[1]  = '{3'd2, 8'd5,   8'd2,   8'd250, 100, 0, 0,  2'd0, 8'd253, 8'd245};
      vecs[2]  = '{3'd6, 8'd4,   8'd10,  8'd20,  100, 0, 0,  2'd0, 8'd14,  8'd20};
      vecs[3]  = '{3'd3, 8'd10,  8'd100, 8'd100, 100, 4, 0,  2'd1, 8'd96,  8'd104};
      vecs[4]  = '{3'd0, 8'd0,   8'd7,   8'd9,   100, 0, 0,  2'd0, 8'd7,   8'd9};
      vecs[5]  = '{3'd7, 8'd9,   8'd1,   8'd2,   100, 0, 0,  2'd3, 8'd1,   8'd2};
      vecs[6]  = '{3'd1, 8'd0,   8'd40,  8'd41,  100, 0, 0,  2'd0, 8'd40,  8'd41};
      vecs[7]  = '{3'd5, 8'd7,   8'd0,   8'd253, 100, 0, 0,  2'd0, 8'd0,   8'd4};
      vecs[8]  = '{3'd4, 8'd6,   8'd3,   8'd3,   50,  0, 0,  2'd0, 8'd9,   8'd253};
      vecs[9]  = '{3'd1, 8'd2,   8'd0,   8'd0,   100, 2, 0,  2'd0, 8'd2,   8'd2};
      vecs[10] = '{3'd1, 8'd8,   8'd50,  8'd60,  0,   0, 30, WDOG ? 2'd2 : 2'd1, 8'd50, 8'd60};
      vecs[11] = '{3'd1, 8'd255, 8'd0,   8'd0,   100, 0, 0,  2'd0, 8'd255, 8'd255};

      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_cnt   = 8'd0;
      abort     = 1'b0;
      left_pos  = 8'd0;
      right_pos = 8'd0;
      repeat (3) step();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_drives", 32'({left_fwd, left_rev, right_fwd, right_rev}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      reset_n = 1'b1;
      step();
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 12; i++)
         do_cmd(vecs[i].op, vecs[i].cnt, vecs[i].sl, vecs[i].sr, vecs[i].tick_pct,
                vecs[i].abort_tick, vecs[i].abort_cyc, 0, 1'b1, vecs[i].st,
                vecs[i].el, vecs[i].er);

      // STOP then illegal op back to back with cmd_valid held throughout.
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = 3'd0;
      cmd_cnt   = 8'd0;
      step();
      chk("stop_done", 32'(done), 32'd1);
      chk("stop_status", 32'(status), 32'd0);
      chk("stop_ready_low", 32'(cmd_ready), 32'd0);
      cmd_op  = 3'd7;
      cmd_cnt = 8'd5;
      step();
      chk("b2b_ready", 32'(cmd_ready), 32'd1);
      chk("b2b_no_done", 32'(done), 32'd0);
      step();
      chk("illegal_done", 32'(done), 32'd1);
      chk("illegal_status", 32'(status), 32'd3);
      chk("illegal_drives", 32'({left_fwd, left_rev, right_fwd, right_rev}), 32'd0);
      chk("illegal_busy", 32'(busy), 32'd0);
      cmd_valid = 1'b0;
      step();
      chk("illegal_ready", 32'(cmd_ready), 32'd1);

      // Reset while idle clears the held illegal status.
      #2 reset_n = 1'b0;
      #1 chk("idle_rst_status", 32'(status), 32'd0);
      step();
      reset_n = 1'b1;
      step();

      // A command held off during a move is taken once the block is ready.
      wait_ready();
      left_pos  = 8'd30;
      right_pos = 8'd30;
      cmd_valid = 1'b1;
      cmd_op    = 3'd1;
      cmd_cnt   = 8'd2;
      acc       = cyc;
      step();
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_drives", 32'({left_fwd, left_rev, right_fwd, right_rev}), 32'hA);
      cmd_op  = 3'd5;
      cmd_cnt = 8'd1;
      abort   = 1'b1;
      step();
      abort = 1'b0;
      chk("hold_abort_done", 32'(done), 32'd1);
      chk("hold_abort_status", 32'(status), 32'd1);
      chk("hold_abort_drives", 32'({left_fwd, left_rev, right_fwd, right_rev}), 32'd0);
      step();
      chk("hold_ready", 32'(cmd_ready), 32'd1);
      step();
      chk("held_cmd_busy", 32'(busy), 32'd1);
      chk("held_cmd_drives", 32'({left_fwd, left_rev, right_fwd, right_rev}), 32'h2);
      chk("held_cmd_timing", 32'(cyc - acc), 32'd4);
      cmd_valid = 1'b0;

      // Reset mid-move clears everything at once and issues no done.
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_drives", 32'({left_fwd, left_rev, right_fwd, right_rev}), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_ready", 32'(cmd_ready), 32'd1);
      chk("midrst_status", 32'(status), 32'd0);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("midrst_no_done", 32'(done), 32'd0);
      end

      for (int i = 0; i < 40; i++) begin
         r_op  = 3'($urandom_range(7));
         r_sel = int'($urandom_range(99));
         r_cnt = (r_sel < 8) ? 8'd0 : (r_sel < 14) ? 8'd255 : 8'($urandom_range(20, 1));
         r_tp  = (r_cnt == 8'd255) ? int'($urandom_range(100, 60)) : int'($urandom_range(100, 20));
         r_ac  = 0;
         if ($urandom_range(9) == 0) begin
            r_tp = 0;
            r_ac = 25;
         end
         do_cmd(r_op, r_cnt, 8'($urandom), 8'($urandom), r_tp, 0, r_ac, 2,
                1'b0, 2'd0, 8'd0, 8'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
